// File: rtl/icache_direct_mapped_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Imported by the interface, the line array and the top.
package icache_direct_mapped_pkg;

  localparam int ICACHE_INDEX_WIDTH = 6;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;

  localparam addr_t ZERO_ADDR = '0;
  localparam inst_t ZERO_WORD = '0;

  typedef enum logic {
    IDLE      = 1'b0,
    MISS_WAIT = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave = cache, master = fetch unit / memory controller side.
interface icache_direct_mapped_if;
  import icache_direct_mapped_pkg::*;

  logic  rdy;
  logic  flush_signal;
  logic  fetch_valid_from_if;
  addr_t pc_from_if;
  logic  inst_valid_to_if;
  inst_t inst_to_if;
  addr_t inst_pc_to_if;
  logic  start_query_to_mem;
  addr_t pc_to_mem;
  logic  finish_query_from_mem;
  inst_t inst_from_mem;

  modport slave (
    input  rdy,
    input  flush_signal,
    input  fetch_valid_from_if,
    input  pc_from_if,
    input  finish_query_from_mem,
    input  inst_from_mem,
    output inst_valid_to_if,
    output inst_to_if,
    output inst_pc_to_if,
    output start_query_to_mem,
    output pc_to_mem
  );

  modport master (
    output rdy,
    output flush_signal,
    output fetch_valid_from_if,
    output pc_from_if,
    output finish_query_from_mem,
    output inst_from_mem,
    input  inst_valid_to_if,
    input  inst_to_if,
    input  inst_pc_to_if,
    input  start_query_to_mem,
    input  pc_to_mem
  );

endinterface

// File: rtl/icache_direct_mapped_line_array.sv
// Valid/tag/data storage: one combinational read port,
// one synchronous write port, valid bits cleared on rst.
module icache_direct_mapped_line_array
  import icache_direct_mapped_pkg::*;
#(
  parameter int IW = ICACHE_INDEX_WIDTH,
  parameter int TW = 32 - 2 - ICACHE_INDEX_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_idx_i,
  output logic          rd_valid_o,
  output logic [TW-1:0] rd_tag_o,
  output inst_t         rd_data_o,
  input  logic          we_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [TW-1:0] wr_tag_i,
  input  inst_t         wr_data_i
);

  localparam int LINES = 1 << IW;

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  inst_t            data_q [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only trusted behind valid.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped I-cache: 1-cycle hits, single outstanding miss
// to the memory controller, flush aborts the miss.
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  icache_direct_mapped_if.slave  bus
);

  localparam int TAG_WIDTH = 32 - 2 - INDEX_WIDTH;

  icache_state_e state_q, state_d;
  addr_t         miss_pc_q, miss_pc_d;
  logic          inst_valid_q, inst_valid_d;
  inst_t         inst_q, inst_d;
  addr_t         inst_pc_q, inst_pc_d;
  logic          start_q, start_d;
  addr_t         pc_mem_q, pc_mem_d;

  logic                   rd_valid;
  logic [TAG_WIDTH-1:0]   rd_tag;
  inst_t                  rd_data;
  logic                   hit;
  logic                   fill;
  logic                   arr_we;

  icache_direct_mapped_line_array #(
    .IW (INDEX_WIDTH),
    .TW (TAG_WIDTH)
  ) u_lines (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (bus.pc_from_if[INDEX_WIDTH+1:2]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (arr_we),
    .wr_idx_i   (miss_pc_q[INDEX_WIDTH+1:2]),
    .wr_tag_i   (miss_pc_q[31:INDEX_WIDTH+2]),
    .wr_data_i  (bus.inst_from_mem)
  );

  assign hit = rd_valid
            && (rd_tag == bus.pc_from_if[31:INDEX_WIDTH+2]);

  assign arr_we = fill && bus.rdy && !rst;

  always_comb begin
    state_d      = state_q;
    miss_pc_d    = miss_pc_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    start_d      = 1'b0;
    pc_mem_d     = pc_mem_q;
    fill         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.fetch_valid_from_if && !bus.flush_signal) begin
          if (hit) begin
            inst_valid_d = 1'b1;
            inst_d       = rd_data;
            inst_pc_d    = bus.pc_from_if;
          end else begin
            miss_pc_d = bus.pc_from_if;
            start_d   = 1'b1;
            pc_mem_d  = bus.pc_from_if;
            state_d   = MISS_WAIT;
          end
        end
      end
      MISS_WAIT: begin
        // A finish racing a flush still fills: the word is correct.
        fill = bus.finish_query_from_mem;
        if (bus.flush_signal) begin
          state_d = IDLE;
        end else if (bus.finish_query_from_mem) begin
          inst_valid_d = 1'b1;
          inst_d       = bus.inst_from_mem;
          inst_pc_d    = miss_pc_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      miss_pc_q    <= ZERO_ADDR;
      inst_valid_q <= 1'b0;
      inst_q       <= ZERO_WORD;
      inst_pc_q    <= ZERO_ADDR;
      start_q      <= 1'b0;
      pc_mem_q     <= ZERO_ADDR;
    end else if (bus.rdy) begin
      state_q      <= state_d;
      miss_pc_q    <= miss_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      start_q      <= start_d;
      pc_mem_q     <= pc_mem_d;
    end
  end

  assign bus.inst_valid_to_if   = inst_valid_q;
  assign bus.inst_to_if         = inst_q;
  assign bus.inst_pc_to_if      = inst_pc_q;
  assign bus.start_query_to_mem = start_q;
  assign bus.pc_to_mem          = pc_mem_q;

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed + randomized bench for icache_direct_mapped against
// a line-map reference model (index/tag by plain arithmetic).
module tb_icache_direct_mapped;
  import icache_direct_mapped_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_direct_mapped_if bus ();

  icache_direct_mapped dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == 24'(pc >> 8));
  endfunction

  task automatic m_fill(logic [31:0] pc, logic [31:0] w);
    m_valid[m_idx(pc)] = 1'b1;
    m_tag[m_idx(pc)]   = 24'(pc >> 8);
    m_data[m_idx(pc)]  = w;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(string tag);
    chk({tag, "_valid"}, 32'(bus.inst_valid_to_if), 32'd0);
    chk({tag, "_start"}, 32'(bus.start_query_to_mem), 32'd0);
  endtask

  task automatic chk_zero_outputs(string tag);
    quiet(tag);
    chk({tag, "_inst"}, bus.inst_to_if, 32'd0);
    chk({tag, "_ipc"}, bus.inst_pc_to_if, 32'd0);
    chk({tag, "_memaddr"}, bus.pc_to_mem, 32'd0);
  endtask

  // mode 0: normal finish, 1: flush without finish, 2: flush+finish
  task automatic fetch(logic [31:0] pc, logic [31:0] w, int lat, int mode);
    bus.fetch_valid_from_if = 1'b1;
    bus.pc_from_if          = pc;
    tick();
    bus.fetch_valid_from_if = 1'b0;
    if (m_hit(pc)) begin
      chk("hit_valid", 32'(bus.inst_valid_to_if), 32'd1);
      chk("hit_inst", bus.inst_to_if, m_data[m_idx(pc)]);
      chk("hit_pc", bus.inst_pc_to_if, pc);
      chk("hit_start", 32'(bus.start_query_to_mem), 32'd0);
      return;
    end
    chk("miss_start", 32'(bus.start_query_to_mem), 32'd1);
    chk("miss_addr", bus.pc_to_mem, pc);
    chk("miss_valid", 32'(bus.inst_valid_to_if), 32'd0);
    for (int i = 0; i < lat; i++) begin
      tick();
      quiet("wait");
      chk("wait_addr", bus.pc_to_mem, pc);
    end
    if (mode == 0) begin
      bus.finish_query_from_mem = 1'b1;
      bus.inst_from_mem         = w;
      tick();
      bus.finish_query_from_mem = 1'b0;
      chk("fill_valid", 32'(bus.inst_valid_to_if), 32'd1);
      chk("fill_inst", bus.inst_to_if, w);
      chk("fill_pc", bus.inst_pc_to_if, pc);
      m_fill(pc, w);
    end else begin
      bus.flush_signal = 1'b1;
      if (mode == 2) begin
        bus.finish_query_from_mem = 1'b1;
        bus.inst_from_mem         = w;
        m_fill(pc, w);
      end
      tick();
      bus.flush_signal          = 1'b0;
      bus.finish_query_from_mem = 1'b0;
      quiet("abort");
    end
  endtask

  initial begin
    logic [31:0] rpc;
    int          r;
    rst                       = 1'b1;
    bus.rdy                   = 1'b1;
    bus.flush_signal          = 1'b0;
    bus.fetch_valid_from_if   = 1'b0;
    bus.pc_from_if            = '0;
    bus.finish_query_from_mem = 1'b0;
    bus.inst_from_mem         = '0;
    m_clear();
    tick();
    tick();
    rst = 1'b0;
    chk_zero_outputs("reset");

    fetch(32'h0, 32'h0000_0013, 2, 0);
    fetch(32'h0, 32'h0, 0, 0);
    fetch(32'h100, 32'hDEAD_BEEF, 1, 0);
    fetch(32'h0, 32'h0000_0013, 0, 0);

    fetch(32'h8, 32'h1111_1111, 1, 1);
    fetch(32'hC, 32'h00C0_0093, 0, 0);
    fetch(32'h10, 32'h2222_2222, 1, 2);
    fetch(32'h10, 32'h0, 0, 0);

    // fetch+flush in IDLE on a hitting pc: dropped
    bus.fetch_valid_from_if = 1'b1;
    bus.flush_signal        = 1'b1;
    bus.pc_from_if          = 32'h0;
    tick();
    bus.fetch_valid_from_if = 1'b0;
    bus.flush_signal        = 1'b0;
    quiet("idle_flush");

    // fetch during MISS_WAIT ignored
    bus.fetch_valid_from_if = 1'b1;
    bus.pc_from_if          = 32'h40;
    tick();
    chk("mw_start", 32'(bus.start_query_to_mem), 32'd1);
    bus.pc_from_if = 32'h0;
    tick();
    bus.fetch_valid_from_if = 1'b0;
    quiet("mw_fetch");
    bus.finish_query_from_mem = 1'b1;
    bus.inst_from_mem         = 32'h4444_4444;
    tick();
    chk("mw_inst", bus.inst_to_if, 32'h4444_4444);
    chk("mw_pc", bus.inst_pc_to_if, 32'h40);
    m_fill(32'h40, 32'h4444_4444);

    // stray finish in IDLE must not write
    bus.inst_from_mem = 32'h5555_5555;
    tick();
    bus.finish_query_from_mem = 1'b0;
    quiet("stray_idle");
    fetch(32'h40, 32'h0, 0, 0);

    // rdy low holds everything, even a flush
    bus.fetch_valid_from_if = 1'b1;
    bus.pc_from_if          = 32'h20;
    tick();
    bus.fetch_valid_from_if = 1'b0;
    chk("rdy_start0", 32'(bus.start_query_to_mem), 32'd1);
    bus.rdy          = 1'b0;
    bus.flush_signal = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_start", 32'(bus.start_query_to_mem), 32'd1);
      chk("rdy_addr", bus.pc_to_mem, 32'h20);
      chk("rdy_valid", 32'(bus.inst_valid_to_if), 32'd0);
    end
    bus.rdy          = 1'b1;
    bus.flush_signal = 1'b0;
    tick();
    quiet("rdy_back");
    bus.finish_query_from_mem = 1'b1;
    bus.inst_from_mem         = 32'h6666_6666;
    tick();
    bus.finish_query_from_mem = 1'b0;
    chk("rdy_fill_valid", 32'(bus.inst_valid_to_if), 32'd1);
    chk("rdy_fill_inst", bus.inst_to_if, 32'h6666_6666);
    m_fill(32'h20, 32'h6666_6666);

    // rst mid-miss, then a stray finish
    bus.fetch_valid_from_if = 1'b1;
    bus.pc_from_if          = 32'h24;
    tick();
    bus.fetch_valid_from_if = 1'b0;
    chk("rst_mw_start", 32'(bus.start_query_to_mem), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_clear();
    chk_zero_outputs("rst_mid");
    bus.finish_query_from_mem = 1'b1;
    bus.inst_from_mem         = 32'h7777_7777;
    tick();
    bus.finish_query_from_mem = 1'b0;
    quiet("rst_stray");
    fetch(32'h24, 32'h8888_8888, 0, 0);
    fetch(32'h0, 32'h0000_0013, 1, 0);
    fetch(32'h10, 32'h2222_2222, 0, 0);

    for (int n = 0; n < 80; n++) begin
      rpc = (32'($urandom_range(0, 3)) << 8)
          | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        bus.fetch_valid_from_if = 1'b1;
        bus.flush_signal        = 1'b1;
        bus.pc_from_if          = rpc;
        tick();
        bus.fetch_valid_from_if = 1'b0;
        bus.flush_signal        = 1'b0;
        quiet("rnd_drop");
      end else begin
        fetch(rpc, $urandom, int'($urandom_range(0, 3)),
              (r == 1) ? 1 : (r == 2) ? 2 : 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
